pathtracer_pad_bridge: RTL and testbench

PATHTRACER_PAD_BRIDGE -- requirements
Module: pathtracer_pad_bridge

---
 rtl/pathtracer_pad_bridge.sv | 184 ++++++++++++++++++
 tb/tb_pathtracer_pad_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pathtracer_pad_bridge.sv
// pathtracer_pad_bridge
//
// Bridges a narrow host pad interface to the wide word streams of the
// pathtracer core, in both directions.
//
//   Input path : PAD_IN_W-bit beats (LSB beat first) are collected into an
//                IN_W-bit word. The word is then presented to the core as a
//                single transfer.
//   Output path: OUT_W-bit pixels from the core are queued in a FIFO_DEPTH-entry
//                FIFO. Each pixel is then serialised to the host as
//                PAD_OUT_W-bit beats, LSB beat first. pad_out_last marks the
//                final beat of each pixel.
//
// Handshake: on every stream a transfer happens at a rising clk edge where
// vld and rdy are both 1. A producer holds dat stable while vld=1 and the
// transfer has not yet happened. No rdy output here depends combinationally
// on a vld or rdy input; each one comes from registered state.
//
// Ports
//   clk                          sole clock, rising edge
//   arst_n                       synchronous active-low reset
//   pad_in_dat/vld/rdy           host -> bridge beats
//   core_in_dat/vld/rdy          bridge -> core words
//   core_out_dat/vld/rdy         core -> bridge pixels
//   pad_out_dat/vld/rdy/last     bridge -> host beats
//   fifo_level                   output FIFO occupancy, 0..FIFO_DEPTH
//
// Supported parameters: IN_W % PAD_IN_W == 0, OUT_W % PAD_OUT_W == 0, and
// FIFO_DEPTH a power of two that is at least 2.
module pathtracer_pad_bridge #(
    parameter int IN_W       = 12,
    parameter int PAD_IN_W   = 4,
    parameter int OUT_W      = 8,
    parameter int PAD_OUT_W  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [PAD_IN_W-1:0]           pad_in_dat,
    input  logic                          pad_in_vld,
    output logic                          pad_in_rdy,
    output logic [IN_W-1:0]               core_in_dat,
    output logic                          core_in_vld,
    input  logic                          core_in_rdy,
    input  logic [OUT_W-1:0]              core_out_dat,
    input  logic                          core_out_vld,
    output logic                          core_out_rdy,
    output logic [PAD_OUT_W-1:0]          pad_out_dat,
    output logic                          pad_out_vld,
    input  logic                          pad_out_rdy,
    output logic                          pad_out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int NB_IN  = IN_W / PAD_IN_W;
    localparam int NB_OUT = OUT_W / PAD_OUT_W;
    // A counter needs at least one bit, even when there is only one beat per word.
    localparam int KW     = (NB_IN  > 1) ? $clog2(NB_IN)  : 1;
    localparam int JW     = (NB_OUT > 1) ? $clog2(NB_OUT) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [KW-1:0] K_LAST = KW'(NB_IN - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NB_OUT - 1);

    // ------------------------------------------------------------------
    // Input path: beat collector FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } in_state_t;

    in_state_t        state_q;
    in_state_t        state_d;
    logic [KW-1:0]    k_q;
    logic [IN_W-1:0]  word_q;
    logic             in_beat;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pad_in_rdy  = 1'b0;
        core_in_vld = 1'b0;
        case (state_q)
            COLLECT: begin
                pad_in_rdy = 1'b1;
                if (pad_in_vld && (k_q == K_LAST)) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                core_in_vld = 1'b1;
                if (core_in_rdy) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign in_beat = pad_in_vld && pad_in_rdy;

    // In PRESENT no beat is accepted, so word_q stays stable.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            k_q    <= '0;
            word_q <= '0;
        end else if (in_beat) begin
            word_q[k_q*PAD_IN_W +: PAD_IN_W] <= pad_in_dat;
            k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
        end
    end

    assign core_in_dat = word_q;

    // ------------------------------------------------------------------
    // Output path: FIFO plus beat serialiser
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [JW-1:0]    j_q;
    logic [OUT_W-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             out_beat;

    // The pointers carry one extra wrap bit. When the index bits are equal,
    // the wrap bits tell full from empty.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign core_out_rdy = !full;
    assign pad_out_vld  = !empty;
    assign pad_out_last = pad_out_vld && (j_q == J_LAST);

    assign push     = core_out_vld && core_out_rdy;
    assign out_beat = pad_out_vld && pad_out_rdy;
    assign pop      = out_beat && (j_q == J_LAST);

    always_comb begin
        head        = mem[rd_ptr_q[AW-1:0]];
        pad_out_dat = head[j_q*PAD_OUT_W +: PAD_OUT_W];
    end

    // Storage is never reset. Only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= core_out_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            j_q      <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (out_beat) begin
                j_q <= (j_q == J_LAST) ? '0 : j_q + 1'b1;
            end
        end
    end

    // Modular subtraction over AW+1 bits gives 0..FIFO_DEPTH.
    assign fifo_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_pathtracer_pad_bridge.sv
// Testbench for pathtracer_pad_bridge.
//   dut : default parameters (12-bit words from 4-bit beats, 8-bit pixels in
//         one beat, 4-entry FIFO)
//   dut2: OUT_W=8 with PAD_OUT_W=4, used for two-beat pixel serialisation
// Driver tasks queue each expected word or pixel as they issue it. Monitors
// sample on the falling edge and pop and compare on every handshake.
module tb_pathtracer_pad_bridge;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;

    logic [3:0]  pad_in_dat = '0;
    logic        pad_in_vld = 1'b0;
    logic        pad_in_rdy;
    logic [11:0] core_in_dat;
    logic        core_in_vld;
    logic        core_in_rdy = 1'b0;
    logic [7:0]  core_out_dat = '0;
    logic        core_out_vld = 1'b0;
    logic        core_out_rdy;
    logic [7:0]  pad_out_dat;
    logic        pad_out_vld;
    logic        pad_out_rdy = 1'b0;
    logic        pad_out_last;
    logic [2:0]  fifo_level;

    logic [3:0]  b_pad_in_dat = '0;
    logic        b_pad_in_vld = 1'b0;
    logic        b_pad_in_rdy;
    logic [11:0] b_core_in_dat;
    logic        b_core_in_vld;
    logic        b_core_in_rdy = 1'b0;
    logic [7:0]  b_core_out_dat = '0;
    logic        b_core_out_vld = 1'b0;
    logic        b_core_out_rdy;
    logic [3:0]  b_pad_out_dat;
    logic        b_pad_out_vld;
    logic        b_pad_out_rdy = 1'b0;
    logic        b_pad_out_last;
    logic [2:0]  b_fifo_level;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_in_q[$];
    logic [7:0]  exp_out_q[$];

    pathtracer_pad_bridge dut (
        .clk(clk), .arst_n(arst_n),
        .pad_in_dat(pad_in_dat), .pad_in_vld(pad_in_vld), .pad_in_rdy(pad_in_rdy),
        .core_in_dat(core_in_dat), .core_in_vld(core_in_vld), .core_in_rdy(core_in_rdy),
        .core_out_dat(core_out_dat), .core_out_vld(core_out_vld), .core_out_rdy(core_out_rdy),
        .pad_out_dat(pad_out_dat), .pad_out_vld(pad_out_vld), .pad_out_rdy(pad_out_rdy),
        .pad_out_last(pad_out_last), .fifo_level(fifo_level)
    );

    pathtracer_pad_bridge #(.IN_W(12), .PAD_IN_W(4), .OUT_W(8), .PAD_OUT_W(4), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .arst_n(arst_n),
        .pad_in_dat(b_pad_in_dat), .pad_in_vld(b_pad_in_vld), .pad_in_rdy(b_pad_in_rdy),
        .core_in_dat(b_core_in_dat), .core_in_vld(b_core_in_vld), .core_in_rdy(b_core_in_rdy),
        .core_out_dat(b_core_out_dat), .core_out_vld(b_core_out_vld), .core_out_rdy(b_core_out_rdy),
        .pad_out_dat(b_pad_out_dat), .pad_out_vld(b_pad_out_vld), .pad_out_rdy(b_pad_out_rdy),
        .pad_out_last(b_pad_out_last), .fifo_level(b_fifo_level)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors (scoreboard) ----------------
    always @(negedge clk) begin
        if (arst_n && core_in_vld && core_in_rdy) begin
            if (exp_in_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL core_in_unexpected: got 0x%0h expected none", core_in_dat);
            end else begin
                check("core_in_dat", 32'(core_in_dat), 32'(exp_in_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (arst_n && pad_out_vld && pad_out_rdy) begin
            if (exp_out_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL pad_out_unexpected: got 0x%0h expected none", pad_out_dat);
            end else begin
                check("pad_out_dat", 32'(pad_out_dat), 32'(exp_out_q.pop_front()));
                check("pad_out_last", 32'(pad_out_last), 32'd1);
            end
        end
    end

    // ---------------- drivers ----------------
    // Every driver task starts and ends just after a rising edge.
    task automatic send_word(input logic [11:0] w, input bit push_exp, input int nbeats, input int max_gap);
        int t;
        if (push_exp) exp_in_q.push_back(w);
        for (int b = 0; b < nbeats; b++) begin
            pad_in_vld = 1'b0;
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            pad_in_dat = w[b*4 +: 4];
            pad_in_vld = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (pad_in_rdy) break;
                if (++t > 1000) begin
                    n_cmp++; n_err++;
                    $display("FAIL pad_in_timeout: got rdy=0 expected rdy=1 within 1000 cycles");
                    break;
                end
            end
            @(posedge clk); #1;
        end
        pad_in_vld = 1'b0;
    endtask

    task automatic push_pixel(input logic [7:0] p, input bit push_exp, input int max_gap);
        int t;
        core_out_vld = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        core_out_dat = p;
        core_out_vld = 1'b1;
        if (push_exp) exp_out_q.push_back(p);
        t = 0;
        forever begin
            @(negedge clk);
            if (core_out_rdy) break;
            if (++t > 1000) begin
                n_cmp++; n_err++;
                $display("FAIL core_out_timeout: got rdy=0 expected rdy=1 within 1000 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        core_out_vld = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_in_q.size() != 0 || exp_out_q.size() != 0) && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, "_in_left"}, 32'(exp_in_q.size()), 32'd0);
        check({name, "_out_left"}, 32'(exp_out_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] pix;
        bit stim_done;

        // Reset values
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        @(negedge clk);
        check("rst_pad_in_rdy",   32'(pad_in_rdy), 32'd1);
        check("rst_core_in_vld",  32'(core_in_vld), 32'd0);
        check("rst_core_in_dat",  32'(core_in_dat), 32'd0);
        check("rst_core_out_rdy", 32'(core_out_rdy), 32'd1);
        check("rst_pad_out_vld",  32'(pad_out_vld), 32'd0);
        check("rst_pad_out_last", 32'(pad_out_last), 32'd0);
        check("rst_fifo_level",   32'(fifo_level), 32'd0);
        @(posedge clk); #1;

        // Beats 3,B,A assemble to 0xAB3, presented one cycle after the last beat
        send_word(12'hAB3, 1'b1, 3, 0);
        @(negedge clk);
        check("asm_core_in_vld", 32'(core_in_vld), 32'd1);
        check("asm_core_in_dat", 32'(core_in_dat), 32'hAB3);
        check("asm_pad_in_rdy",  32'(pad_in_rdy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_core_in_dat", 32'(core_in_dat), 32'hAB3);
        check("hold_pad_in_rdy",  32'(pad_in_rdy), 32'd0);
        @(posedge clk); #1;
        core_in_rdy = 1'b1;
        @(posedge clk); #1;
        core_in_rdy = 1'b0;
        @(negedge clk);
        check("bubble_pad_in_rdy",  32'(pad_in_rdy), 32'd1);
        check("bubble_core_in_vld", 32'(core_in_vld), 32'd0);
        @(posedge clk); #1;

        // Fill the FIFO to full, then drain it
        push_pixel(8'h11, 1'b1, 0);
        push_pixel(8'h22, 1'b1, 0);
        push_pixel(8'h33, 1'b1, 0);
        push_pixel(8'h44, 1'b1, 0);
        @(negedge clk);
        check("full_fifo_level",   32'(fifo_level), 32'd4);
        check("full_core_out_rdy", 32'(core_out_rdy), 32'd0);
        check("full_pad_out_vld",  32'(pad_out_vld), 32'd1);
        @(posedge clk); #1;
        pad_out_rdy = 1'b1;
        wait_drained("drain4", 50);
        @(negedge clk);
        check("drain4_fifo_level", 32'(fifo_level), 32'd0);
        check("drain4_pad_out_vld", 32'(pad_out_vld), 32'd0);
        @(posedge clk); #1;

        // Level 2, then simultaneous push and pop across a pointer wrap
        pad_out_rdy = 1'b0;
        push_pixel(8'hA0, 1'b1, 0);
        push_pixel(8'hA1, 1'b1, 0);
        pad_out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pix = 8'($urandom);
            core_out_dat = pix;
            core_out_vld = 1'b1;
            exp_out_q.push_back(pix);
            @(negedge clk);
            check("pp_fifo_level",   32'(fifo_level), 32'd2);
            check("pp_core_out_rdy", 32'(core_out_rdy), 32'd1);
            @(posedge clk); #1;
        end
        core_out_vld = 1'b0;
        wait_drained("pp", 50);
        pad_out_rdy = 1'b0;

        // Two-beat serialisation on dut2: 0xC5 -> 0x5 then 0xC
        b_pad_out_rdy  = 1'b1;
        b_core_out_dat = 8'hC5;
        b_core_out_vld = 1'b1;
        @(posedge clk); #1;
        b_core_out_vld = 1'b0;
        @(negedge clk);
        check("ser_b0_vld",  32'(b_pad_out_vld), 32'd1);
        check("ser_b0_dat",  32'(b_pad_out_dat), 32'h5);
        check("ser_b0_last", 32'(b_pad_out_last), 32'd0);
        check("ser_b0_level", 32'(b_fifo_level), 32'd1);
        @(negedge clk);
        check("ser_b1_dat",  32'(b_pad_out_dat), 32'hC);
        check("ser_b1_last", 32'(b_pad_out_last), 32'd1);
        check("ser_b1_level", 32'(b_fifo_level), 32'd1);
        @(negedge clk);
        check("ser_done_vld",   32'(b_pad_out_vld), 32'd0);
        check("ser_done_level", 32'(b_fifo_level), 32'd0);
        @(posedge clk); #1;
        b_pad_out_rdy = 1'b0;

        // Reset mid-word and with 3 FIFO entries discards everything
        send_word(12'hFED, 1'b0, 2, 0);
        push_pixel(8'h91, 1'b0, 0);
        push_pixel(8'h92, 1'b0, 0);
        push_pixel(8'h93, 1'b0, 0);
        @(negedge clk);
        check("prerst_fifo_level", 32'(fifo_level), 32'd3);
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(negedge clk);
        check("rst2_pad_in_rdy",  32'(pad_in_rdy), 32'd1);
        check("rst2_fifo_level",  32'(fifo_level), 32'd0);
        check("rst2_pad_out_vld", 32'(pad_out_vld), 32'd0);
        @(posedge clk); #1;
        core_in_rdy = 1'b1;
        send_word(12'h321, 1'b1, 3, 0);
        wait_drained("rst2", 20);
        core_in_rdy = 1'b0;

        // Randomised traffic on both paths: 1000 words each way
        stim_done = 1'b0;
        fork
            begin
                fork
                    for (int i = 0; i < 1000; i++) send_word(12'($urandom), 1'b1, 3, 2);
                    for (int i = 0; i < 1000; i++) push_pixel(8'($urandom), 1'b1, 3);
                join
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    core_in_rdy = ($urandom_range(0, 3) != 0);
                    pad_out_rdy = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        core_in_rdy = 1'b1;
        pad_out_rdy = 1'b1;
        wait_drained("rand", 200);
        @(negedge clk);
        check("rand_fifo_level", 32'(fifo_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
